// File: rtl/sr04_multi.sv
// Round-robin HC-SR04 scanner: triggers each sensor in turn and measures its echo high time in clk cycles.
// Optional build macro SR04_GLITCH_FILTER_EN adds a 3-sample glitch filter behind each echo synchroniser.
module sr04_multi #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 24,
  parameter int TRIG_CYCLES    = 160,
  parameter int TIMEOUT_CYCLES = 480000,
  parameter int HOLDOFF_CYCLES = 960000,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [CHANNELS-1:0] sensor_trigger_out,
  input  logic [CHANNELS-1:0] sensor_echo_in,
  output logic [WIDTH-1:0]    value,
  output logic [CH_W-1:0]     value_ch,
  output logic                value_ok,
  output logic                timeout,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  localparam logic [WIDTH-1:0] TRIG_LAST = WIDTH'(TRIG_CYCLES - 1);
  localparam logic [WIDTH-1:0] TMO_LAST  = WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] HOLD_LAST = WIDTH'(HOLDOFF_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNELS - 1);

  logic [CHANNELS-1:0] sync_q1, sync_q2, echo_vec;
  logic                echo;

  state_t              state, state_n;
  logic [CH_W-1:0]     ch, ch_n;
  logic [WIDTH-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0]    value_n;
  logic [CH_W-1:0]     value_ch_n;
  logic                value_ok_n, timeout_n;
  logic [CHANNELS-1:0] trig_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sensor_echo_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef SR04_GLITCH_FILTER_EN
  logic [CHANNELS-1:0] hist_a, hist_b, filt_q, stable;

  // Level follows the input only once three consecutive samples agree; both edges gain 2 cycles.
  assign stable   = ~(sync_q2 ^ hist_a) & ~(sync_q2 ^ hist_b);
  assign echo_vec = (stable & sync_q2) | (~stable & filt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_a <= '0;
      hist_b <= '0;
      filt_q <= '0;
    end else begin
      hist_a <= sync_q2;
      hist_b <= hist_a;
      filt_q <= echo_vec;
    end
  end
`else
  assign echo_vec = sync_q2;
`endif

  assign echo = echo_vec[ch];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      ch                 <= '0;
      cnt                <= '0;
      value              <= '0;
      value_ch           <= '0;
      value_ok           <= 1'b0;
      timeout            <= 1'b0;
      sensor_trigger_out <= '0;
    end else begin
      state              <= state_n;
      ch                 <= ch_n;
      cnt                <= cnt_n;
      value              <= value_n;
      value_ch           <= value_ch_n;
      value_ok           <= value_ok_n;
      timeout            <= timeout_n;
      sensor_trigger_out <= trig_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    ch_n       = ch;
    cnt_n      = cnt;
    value_n    = value;
    value_ch_n = value_ch;
    value_ok_n = 1'b0;
    timeout_n  = 1'b0;
    trig_n     = '0;

    case (state)
      IDLE: begin
        if (en) begin
          cnt_n = '0;
          if (echo) begin
            timeout_n  = 1'b1;
            value_n    = '0;
            value_ch_n = ch;
            state_n    = HOLDOFF;
          end else begin
            state_n = TRIG;
          end
        end
      end
      TRIG: begin
        if (cnt == TRIG_LAST) begin
          cnt_n   = '0;
          state_n = WAIT_RISE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_RISE: begin
        // The first high sample is already one cycle of echo, hence the count starts at 1.
        if (echo) begin
          cnt_n   = WIDTH'(1);
          state_n = MEASURE;
        end else if (cnt == TMO_LAST) begin
          timeout_n  = 1'b1;
          value_n    = '0;
          value_ch_n = ch;
          cnt_n      = '0;
          state_n    = HOLDOFF;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      MEASURE: begin
        if (!echo) begin
          value_ok_n = 1'b1;
          value_n    = cnt;
          value_ch_n = ch;
          cnt_n      = '0;
          state_n    = HOLDOFF;
        end else if (cnt == TMO_LAST) begin
          timeout_n  = 1'b1;
          value_n    = '0;
          value_ch_n = ch;
          cnt_n      = '0;
          state_n    = HOLDOFF;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          ch_n    = (ch == CH_LAST) ? '0 : ch + 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n == TRIG) trig_n[ch_n] = 1'b1;
  end

endmodule

// File: doc/sr04_multi.md
Name: sr04_multi

Overview:
- Multi-channel successor to the single-sensor HC-SR04 controller.
- Scans CHANNELS ultrasonic sensors round-robin: issues a trigger pulse, then measures the echo pulse width in clock cycles.
- Reports each result tagged with its channel number; the downstream distance logic and UART reporter consume it.
- Adds over the single-channel version: true pulse-width measurement, echo synchronisation, timeout reporting, inter-measurement holdoff and parametrised widths.

Parameters:
- CHANNELS, 4, number of sensors (>=1)
- WIDTH, 24, width of measured value
- TRIG_CYCLES, 160, trigger high time in clk cycles (10 us at 16 MHz)
- TIMEOUT_CYCLES, 480000, max wait for echo rise and max echo high time (30 ms); must be < 2^WIDTH
- HOLDOFF_CYCLES, 960000, quiet time after each measurement before the next channel (60 ms)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  scan enable
- sensor_trigger_out  out  CHANNELS  per-sensor trigger
- sensor_echo_in  in  CHANNELS  per-sensor echo (asynchronous)
- value  out  WIDTH  echo high time in cycles
- value_ch  out  max(1,$clog2(CHANNELS))  channel of value / timeout
- value_ok  out  1  one-cycle pulse: valid measurement
- timeout  out  1  one-cycle pulse: channel timed out or echo stuck high
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous): state IDLE, channel pointer 0, all counters 0, all outputs 0, synchroniser flops 0.
- Synchronisation:
  - Each echo bit passes through a 2-flop synchroniser.
  - "echo" below means the synchronised bit of the current channel.
  - Both edges are delayed equally, so the width is preserved.
- IDLE:
  - en=1 and echo=0 -> TRIG.
  - en=1 and echo=1 -> stuck echo: pulse timeout, value<=0, value_ch<=ch, -> HOLDOFF.
  - en=0 -> stay.
- TRIG:
  - sensor_trigger_out[ch]=1 for exactly TRIG_CYCLES cycles; all other bits 0.
  - Then -> WAIT_RISE, counter cleared.
- WAIT_RISE:
  - Counter increments each cycle.
  - echo=1 -> MEASURE, count<=1.
  - Counter reaches TIMEOUT_CYCLES-1 with echo still 0 -> timeout pulse, value<=0, value_ch<=ch, -> HOLDOFF.
- MEASURE:
  - echo=1 -> count increments.
  - echo=0 -> value<=count, value_ch<=ch, value_ok pulse, -> HOLDOFF.
  - count reaches TIMEOUT_CYCLES with echo still 1 -> timeout pulse, value<=0, -> HOLDOFF.
  - Result: an echo high for N cycles at the pin yields value=N, with 1 <= N < TIMEOUT_CYCLES.
- HOLDOFF:
  - All triggers low for HOLDOFF_CYCLES cycles.
  - Then the pointer advances (CHANNELS-1 wraps to 0) -> IDLE.
- Output timing and exclusivity:
  - value_ok and timeout are never high together.
  - Each is high for exactly one cycle, registered, and asserted in the cycle the state enters HOLDOFF.
- value and value_ch hold until the next value_ok or timeout.
- en deasserted mid-sequence: the current channel completes, including HOLDOFF. The block then parks in IDLE, with the pointer advanced.
- Only one trigger bit is ever high at a time.
- Echo activity on non-selected channels is ignored.
- Counters are WIDTH bits. With TIMEOUT_CYCLES < 2^WIDTH, no wrap can occur.

Optional Feature:
- SR04_GLITCH_FILTER_EN defined:
  - After the synchroniser, each echo bit is filtered: the filtered level changes only after 3 consecutive equal samples.
  - Adds 2 cycles of latency to both edges; N is unchanged for pulses >= 3 cycles.
  - High or low glitches of 1-2 cycles are removed.
- Not defined: the synchronised echo is used directly; 1-cycle pulses are measured as value=1.

Test Plan (CHANNELS=2, WIDTH=8, TRIG_CYCLES=10, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=5):
- Reset, en=1, both echo=0 -> sensor_trigger_out=2'b01 for exactly 10 cycles; after 100 wait cycles timeout=1 (1 cycle) with value_ch=0, value=0; next trigger goes to 2'b10 after 5 holdoff cycles.
- ch0 echo high 37 cycles, starting 20 cycles after trigger fall -> value_ok pulse, value=37, value_ch=0; then ch1 triggered.
- ch1 echo held high 150 cycles -> timeout pulse at count 100, value=0, value_ch=1; pointer wraps to ch0.
- ch0 echo already high when en rises -> immediate timeout, value_ch=0, no trigger on ch0; ch1 next.
- Assert reset mid-MEASURE -> all outputs 0 immediately (asynchronous), pointer 0; after release with en=1, trigger restarts on ch0.
- With SR04_GLITCH_FILTER_EN: 2-cycle echo blip then 40-cycle pulse -> value=40. Without the macro: the same stimulus yields value=2.
